// File: rtl/wts_envelope_generator_pkg.sv
// Shared envelope-generator definitions: FSM state encodings and level constants.
package wts_envelope_generator_pkg;

  localparam logic [5:0] LEVEL_MAX  = 6'd63;
  localparam logic [6:0] ENV_BYPASS = 7'h40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  // States in which releasing the key starts the release phase.
  function automatic logic is_keyed_state(input env_state_e s);
    return (s == ST_ATTACK) || (s == ST_DECAY) || (s == ST_SUSTAIN);
  endfunction

  // States in which the level moves at the programmed rate.
  function automatic logic is_ramp_state(input env_state_e s);
    return (s == ST_ATTACK) || (s == ST_DECAY) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/wts_env_rate_counter.sv
// Per-phase rate divider: one level step every `rate` active ticks, or an
// instant jump when the rate is zero.
module wts_env_rate_counter (
  input  logic       clk,
  input  logic       nreset,
  input  logic       active,
  input  logic       clear,
  input  logic [7:0] rate,
  output logic       step,
  output logic       instant
);

  logic [7:0] count_q, count_d;

  assign instant = (rate == 8'd0);
  // >= rather than == so lowering the rate mid-phase never lets the count run away.
  assign step    = active && !instant && (count_q >= (rate - 8'd1));

  always_comb begin
    count_d = count_q;
    if (active) begin
      if (clear || instant || step) count_d = 8'd0;
      else                          count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) count_q <= 8'd0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/wts_envelope_generator.sv
// Per-channel ADSR envelope generator; envelope = {bypass, level[5:0]}.
// state   | meaning
// IDLE    | silent, level 0
// ATTACK  | level rising toward 63
// DECAY   | level falling toward sustain level
// SUSTAIN | level held while key is down
// RELEASE | level falling toward 0 after key-off
module wts_envelope_generator
  import wts_envelope_generator_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       active,
  input  logic       reg_key_on,
  input  logic       reg_adsr_en,
  input  logic [7:0] reg_ar,
  input  logic [7:0] reg_dr,
  input  logic [5:0] reg_sl,
  input  logic [7:0] reg_rr,
  output logic [6:0] envelope,
  output logic       busy
);

  env_state_e state_q, state_d;
  logic [5:0] level_q, level_d;
  logic       prev_key_q, prev_key_d;
  logic [6:0] envelope_q;
  logic       busy_q;

  logic [7:0] rate;
  logic       step, instant, cnt_clear;
  logic       key_rise, key_off;
  logic [5:0] level_inc, level_dec;

  assign key_rise  = reg_key_on && !prev_key_q;
  assign key_off   = !reg_key_on && is_keyed_state(state_q);
  assign level_inc = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + 6'd1;
  assign level_dec = (level_q == 6'd0) ? 6'd0 : level_q - 6'd1;

  always_comb begin
    rate = 8'd0;
    case (state_q)
      ST_ATTACK:  rate = reg_ar;
      ST_DECAY:   rate = reg_dr;
      ST_RELEASE: rate = reg_rr;
      default:    rate = 8'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    prev_key_d = prev_key_q;
    if (active) begin
      prev_key_d = reg_key_on;
      // Key events win over any level step in the same tick.
      if (key_rise) begin
        state_d = ST_ATTACK;
      end else if (key_off) begin
        state_d = ST_RELEASE;
      end else begin
        case (state_q)
          ST_IDLE: level_d = 6'd0;
          ST_ATTACK: begin
            if (instant) begin
              level_d = LEVEL_MAX;
              state_d = (reg_sl == LEVEL_MAX) ? ST_SUSTAIN : ST_DECAY;
            end else if (step) begin
              level_d = level_inc;
              if (level_inc == LEVEL_MAX)
                state_d = (reg_sl == LEVEL_MAX) ? ST_SUSTAIN : ST_DECAY;
            end
          end
          ST_DECAY: begin
            if (level_q <= reg_sl) begin
              state_d = ST_SUSTAIN;
            end else if (instant) begin
              level_d = reg_sl;
              state_d = ST_SUSTAIN;
            end else if (step) begin
              level_d = level_dec;
              if (level_dec <= reg_sl) state_d = ST_SUSTAIN;
            end
          end
          ST_SUSTAIN: level_d = level_q;
          ST_RELEASE: begin
            if (level_q == 6'd0) begin
              state_d = ST_IDLE;
            end else if (instant) begin
              level_d = 6'd0;
              state_d = ST_IDLE;
            end else if (step) begin
              level_d = level_dec;
              if (level_dec == 6'd0) state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            level_d = 6'd0;
          end
        endcase
      end
    end
  end

  assign cnt_clear = key_rise || key_off || (state_d != state_q) || !is_ramp_state(state_q);

  wts_env_rate_counter u_rate (
    .clk     (clk),
    .nreset  (nreset),
    .active  (active),
    .clear   (cnt_clear),
    .rate    (rate),
    .step    (step),
    .instant (instant)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      level_q    <= 6'd0;
      prev_key_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      prev_key_q <= prev_key_d;
    end
  end

  // Outputs lag the state by one clock; the bypass flag is not gated by active.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      envelope_q <= 7'h00;
      busy_q     <= 1'b0;
    end else begin
      envelope_q <= reg_adsr_en ? {1'b0, level_q} : ENV_BYPASS;
      busy_q     <= (state_q != ST_IDLE);
    end
  end

  assign envelope = envelope_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wts_envelope_generator.sv
// Directed bench for wts_envelope_generator: vector table plus reset/strobe sequences.
module tb_wts_envelope_generator;

  logic       clk = 1'b0;
  logic       nreset;
  logic       active;
  logic       key;
  logic       en;
  logic [7:0] ar, dr, rr;
  logic [5:0] sl;
  logic [6:0] envelope;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       key;
    logic       en;
    logic [7:0] ar;
    logic [7:0] dr;
    logic [5:0] sl;
    logic [7:0] rr;
    int         ncyc;
    logic [6:0] env;
    logic       busy;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  wts_envelope_generator dut (
    .clk         (clk),
    .nreset      (nreset),
    .active      (active),
    .reg_key_on  (key),
    .reg_adsr_en (en),
    .reg_ar      (ar),
    .reg_dr      (dr),
    .reg_sl      (sl),
    .reg_rr      (rr),
    .envelope    (envelope),
    .busy        (busy)
  );

  function automatic vec_t mk(input logic k, input logic e, input logic [7:0] a,
                              input logic [7:0] d, input logic [5:0] s, input logic [7:0] r,
                              input int n, input logic [6:0] ev, input logic b);
    vec_t v;
    v.key = k; v.en = e; v.ar = a; v.dr = d; v.sl = s; v.rr = r;
    v.ncyc = n; v.env = ev; v.busy = b;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] env_exp, input logic busy_exp);
    total++;
    if (envelope !== env_exp) begin
      bad++;
      $display("FAIL %s envelope: got %h want %h", name, envelope, env_exp);
    end
    total++;
    if (busy !== busy_exp) begin
      bad++;
      $display("FAIL %s busy: got %b want %b", name, busy, busy_exp);
    end
  endtask

  initial begin
    // attack 0->63 at AR=2, decay to 32 at DR=1, sustain
    vecs[0]  = mk(1, 1, 2, 1, 32, 4, 127, 7'd62, 1);
    vecs[1]  = mk(1, 1, 2, 1, 32, 4,   1, 7'd63, 1);
    vecs[2]  = mk(1, 1, 2, 1, 32, 4,  30, 7'd33, 1);
    vecs[3]  = mk(1, 1, 2, 1, 32, 4,   1, 7'd32, 1);
    vecs[4]  = mk(1, 1, 2, 1, 32, 4,  20, 7'd32, 1);
    // release 32->0 at RR=4
    vecs[5]  = mk(0, 1, 2, 1, 32, 4, 129, 7'd1,  1);
    vecs[6]  = mk(0, 1, 2, 1, 32, 4,   1, 7'd0,  0);
    // instant attack to sustain 63, instant release
    vecs[7]  = mk(1, 1, 0, 1, 63, 4,   2, 7'd0,  1);
    vecs[8]  = mk(1, 1, 0, 1, 63, 4,   1, 7'd63, 1);
    vecs[9]  = mk(0, 1, 0, 1, 63, 0,   2, 7'd63, 1);
    vecs[10] = mk(0, 1, 0, 1, 63, 0,   1, 7'd0,  0);
    // bypass while attacking
    vecs[11] = mk(1, 1, 2, 1, 32, 4,  21, 7'd9,  1);
    vecs[12] = mk(1, 0, 2, 1, 32, 4,   1, 7'h40, 1);
    vecs[13] = mk(1, 0, 2, 1, 32, 4,  10, 7'h40, 1);
    vecs[14] = mk(1, 1, 2, 1, 32, 4,   1, 7'd15, 1);
    // retrigger from level 40 during release
    vecs[15] = mk(1, 1, 0, 1, 63, 4,   2, 7'd63, 1);
    vecs[16] = mk(0, 1, 0, 1, 63, 1,  24, 7'd41, 1);
    vecs[17] = mk(1, 1, 2, 1, 63, 1,   1, 7'd40, 1);
    vecs[18] = mk(1, 1, 2, 1, 63, 1,   1, 7'd40, 1);
    vecs[19] = mk(1, 1, 2, 1, 63, 1,   2, 7'd41, 1);
    // into a slow decay before the reset sequence
    vecs[20] = mk(1, 1, 0, 8, 10, 4,   5, 7'd63, 1);

    nreset = 1'b1; active = 1'b1; key = 1'b0; en = 1'b1;
    ar = 8'd2; dr = 8'd1; sl = 6'd32; rr = 8'd4;
    #1 nreset = 1'b0;
    #1 check("reset", 7'h00, 1'b0);
    @(negedge clk);
    nreset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      key = vecs[i].key; en = vecs[i].en;
      ar = vecs[i].ar; dr = vecs[i].dr; sl = vecs[i].sl; rr = vecs[i].rr;
      repeat (vecs[i].ncyc) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].env, vecs[i].busy);
    end

    // asynchronous reset mid-decay, no clock edge in between
    #1 nreset = 1'b0;
    #1 check("async_reset", 7'h00, 1'b0);
    repeat (2) @(negedge clk);
    ar = 8'd2; dr = 8'd1; sl = 6'd32;
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_attack", 7'd0, 1'b1);
    repeat (2) @(negedge clk);
    check("post_reset_step", 7'd1, 1'b1);

    // without the strobe nothing advances
    active = 1'b0;
    repeat (10) @(negedge clk);
    check("no_active_hold", 7'd1, 1'b1);
    active = 1'b1;
    repeat (2) @(negedge clk);
    check("active_resume", 7'd2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
